// File: rtl/dram_rst_pkg.sv
// Shared types and constants for the DRAM-domain reset sequencer.
package dram_rst_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_REL0,
    ST_WAIT_CALIB,
    ST_STAGGER,
    ST_RUN
  } rst_state_t;

  localparam int RST_SYNC_MIN = 2;

endpackage

// File: rtl/sync_chain.sv
// Async-clear flop chain used to bring reset release and calib status into the sys-clock domain.
module sync_chain #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/dram_reset_sequencer.sv
// Ordered reset release for the DRAM sys-clock domain: controller reset first, user
// resets staggered after calibration, with timeout flagging and re-reset on request or calib loss.
module dram_reset_sequencer
  import dram_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned NUM_RST        = 3,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned CALIB_TIMEOUT  = 2**20
) (
  input  logic               clk_166_67_mhz,
  input  logic               dram_rstx_async,
  input  logic               i_sw_rst_req,
  input  logic               i_init_calib_complete,
  output logic [NUM_RST-1:0] o_rst,
  output logic               o_all_released,
  output logic               o_calib_timeout,
  output logic [2:0]         o_state
);

  localparam int unsigned SYNC_MIN_U = unsigned'(RST_SYNC_MIN);
  localparam int unsigned SYNC_N     = (SYNC_STAGES < SYNC_MIN_U) ? SYNC_MIN_U : SYNC_STAGES;
  localparam int unsigned CNT_HS     = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CNT_MAX    = (CALIB_TIMEOUT > CNT_HS) ? CALIB_TIMEOUT : CNT_HS;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W      = $clog2(NUM_RST);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_RST - 1);

  logic               rst_s;
  logic               calib_s;
  rst_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_RST-1:0] rst_q, rst_d;
  logic               all_rel_q, all_rel_d;
  logic               timeout_q, timeout_d;
  logic               rereset;

  // Reset release chain holds 1 until the async reset has been gone for SYNC_N edges
  sync_chain #(
    .STAGES    (SYNC_N),
    .RESET_VAL (1'b1)
  ) u_rst_sync (
    .clk   (clk_166_67_mhz),
    .rst_n (dram_rstx_async),
    .d     (1'b0),
    .q     (rst_s)
  );

  sync_chain #(
    .STAGES    (SYNC_N),
    .RESET_VAL (1'b0)
  ) u_calib_sync (
    .clk   (clk_166_67_mhz),
    .rst_n (dram_rstx_async),
    .d     (i_init_calib_complete),
    .q     (calib_s)
  );

  always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
    if (!dram_rstx_async) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_q     <= '1;
      all_rel_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_q     <= rst_d;
      all_rel_q <= all_rel_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and next-output logic; the timeout counter saturates at its terminal value
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_d     = rst_q;
    timeout_d = timeout_q;
    rereset   = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        rst_d = '1;
        cnt_d = '0;
        if (!rst_s && !i_sw_rst_req) begin
          state_d   = ST_HOLD;
          timeout_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_REL0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REL0: begin
        rst_d[0] = 1'b0;
        cnt_d    = '0;
        state_d  = ST_WAIT_CALIB;
      end
      ST_WAIT_CALIB: begin
        if (i_sw_rst_req) begin
          rereset = 1'b1;
        end else if (calib_s) begin
          state_d = ST_STAGGER;
          idx_d   = IDX_W'(1);
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STAGGER: begin
        if (i_sw_rst_req || !calib_s) begin
          rereset = 1'b1;
        end else if (cnt_q == STAGGER_LAST) begin
          rst_d[idx_q] = 1'b0;
          cnt_d        = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        rst_d = '0;
        if (i_sw_rst_req || !calib_s) begin
          rereset = 1'b1;
        end
      end
      default: begin
        rereset = 1'b1;
      end
    endcase

    if (rereset) begin
      state_d = ST_ASSERT;
      rst_d   = '1;
      cnt_d   = '0;
    end

    all_rel_d = (rst_d == '0);
  end

  assign o_rst           = rst_q;
  assign o_all_released  = all_rel_q;
  assign o_calib_timeout = timeout_q;
  assign o_state         = state_q;

endmodule
